// File: rtl/riscv_pkg.sv
// Shared RV32I fetch-stage definitions: reset/bubble constants, fetch FSM states
// and a word-alignment helper for redirect targets.
package riscv_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master)
// and the instruction memory (slave).
interface fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_valid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_valid
  );

endinterface

// File: rtl/fetch_hold_buf.sv
// Single-entry {pc, instr} register that parks a fetched instruction while
// the hazard unit stalls IF/ID.
module fetch_hold_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o
);

  logic        valid_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;

  // Load takes precedence so a same-cycle clear/refill keeps the new entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= 32'h0;
      instr_q <= 32'h0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      instr_q <= instr_i;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/fetch_unit.sv
// RV32I IF stage: owns the PC, issues instruction fetches, loads IF/ID and
// handles hazard stalls plus branch/jump redirects with wrong-path discard.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                branch_taken_i,
  input  logic [31:0]         branch_target_i,
  input  logic                jump_i,
  input  logic [31:0]         jump_target_i,
  input  logic                stall_i,
  fetch_unit_if.master        imem,
  output logic [31:0]         if_id_pc_o,
  output logic [31:0]         if_id_instr_o,
  output logic                if_id_valid_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  redirect_pc_q, redirect_pc_d;
  logic [31:0]  if_id_pc_q, if_id_pc_d;
  logic [31:0]  if_id_instr_q, if_id_instr_d;
  logic         if_id_valid_q, if_id_valid_d;

  logic         redirect;
  logic [31:0]  target;
  logic         hb_load, hb_clear, hb_valid;
  logic [31:0]  hb_pc, hb_instr;
  logic         ifid_load;
  logic [31:0]  ifid_load_pc, ifid_load_instr;

  // Branch outranks jump when both fire in the same cycle.
  assign redirect = branch_taken_i | jump_i;
  assign target   = align_word(branch_taken_i ? branch_target_i : jump_target_i);

  fetch_hold_buf u_hold_buf (
    .clk     (clk),
    .rst     (rst),
    .load_i  (hb_load),
    .clear_i (hb_clear),
    .pc_i    (pc_q),
    .instr_i (imem.imem_rdata),
    .valid_o (hb_valid),
    .pc_o    (hb_pc),
    .instr_o (hb_instr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      redirect_pc_q <= 32'h0;
      if_id_pc_q    <= 32'h0;
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      redirect_pc_q <= redirect_pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    redirect_pc_d   = redirect_pc_q;
    hb_load         = 1'b0;
    hb_clear        = 1'b0;
    ifid_load       = 1'b0;
    ifid_load_pc    = pc_q;
    ifid_load_instr = imem.imem_rdata;

    unique case (state_q)
      RUN: begin
        if (redirect) begin
          // An outstanding request cannot be aborted, so without a response
          // the redirect is parked until the stale one drains.
          if (imem.imem_valid) begin
            pc_d = target;
          end else begin
            redirect_pc_d = target;
            state_d       = DISCARD;
          end
        end else if (imem.imem_valid) begin
          pc_d = pc_q + 32'd4;
          if (stall_i) begin
            hb_load = 1'b1;
            state_d = HOLD;
          end else begin
            ifid_load = 1'b1;
          end
        end
      end
      HOLD: begin
        if (redirect) begin
          hb_clear = 1'b1;
          pc_d     = target;
          state_d  = RUN;
        end else if (!stall_i) begin
          ifid_load       = hb_valid;
          ifid_load_pc    = hb_pc;
          ifid_load_instr = hb_instr;
          hb_clear        = 1'b1;
          state_d         = RUN;
        end
      end
      DISCARD: begin
        if (imem.imem_valid) begin
          pc_d    = redirect ? target : redirect_pc_q;
          state_d = RUN;
        end else if (redirect) begin
          redirect_pc_d = target;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // IF/ID: flush beats everything, stall freezes, otherwise load or bubble.
  always_comb begin
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    if (redirect) begin
      if_id_instr_d = NOP_INSTR;
      if_id_valid_d = 1'b0;
    end else if (ifid_load) begin
      if_id_pc_d    = ifid_load_pc;
      if_id_instr_d = ifid_load_instr;
      if_id_valid_d = 1'b1;
    end else if (!stall_i) begin
      if_id_instr_d = NOP_INSTR;
      if_id_valid_d = 1'b0;
    end
  end

  always_comb begin
    imem.imem_req  = ~rst & (state_q != HOLD);
    imem.imem_addr = pc_q;
    if_id_pc_o     = if_id_pc_q;
    if_id_instr_o  = if_id_instr_q;
    if_id_valid_o  = if_id_valid_q;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit against a behavioural instruction memory with
// programmable response latency.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic        jump;
  logic [31:0] jumpTarget;
  logic        stall;
  logic [31:0] ifIdPc;
  logic [31:0] ifIdInstr;
  logic        ifIdValid;

  logic [3:0]  memLatency;
  logic [3:0]  waitCnt;
  logic        dataMode;

  int testsRun;
  int testsFailed;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .branch_taken_i  (branchTaken),
    .branch_target_i (branchTarget),
    .jump_i          (jump),
    .jump_target_i   (jumpTarget),
    .stall_i         (stall),
    .imem            (bus),
    .if_id_pc_o      (ifIdPc),
    .if_id_instr_o   (ifIdInstr),
    .if_id_valid_o   (ifIdValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory answers once the request has waited memLatency cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) waitCnt <= 4'd0;
    else if (bus.imem_req && !bus.imem_valid) waitCnt <= waitCnt + 4'd1;
    else waitCnt <= 4'd0;
  end

  assign bus.imem_valid = bus.imem_req && (waitCnt >= memLatency);
  assign bus.imem_rdata = dataMode ? (32'hA000_0000 | bus.imem_addr) : 32'h0000_0013;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic bt, input logic [31:0] btgt,
                               input logic j, input logic [31:0] jtgt, input logic st);
    branchTaken  = bt;
    branchTarget = btgt;
    jump         = j;
    jumpTarget   = jtgt;
    stall        = st;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    memLatency  = 4'd0;
    dataMode    = 1'b0;
    rst         = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("rst_req",   {31'h0, bus.imem_req}, 32'h0);
    checkOutput("rst_valid", {31'h0, ifIdValid}, 32'h0);
    checkOutput("rst_instr", ifIdInstr, 32'h0000_0013);
    checkOutput("rst_pc",    ifIdPc, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("boot_addr", bus.imem_addr, 32'h0);
    checkOutput("boot_req",  {31'h0, bus.imem_req}, 32'h1);

    // Zero-wait streaming
    tick();
    checkOutput("s1_ifid_pc",    ifIdPc, 32'h0);
    checkOutput("s1_ifid_instr", ifIdInstr, 32'h0000_0013);
    checkOutput("s1_ifid_valid", {31'h0, ifIdValid}, 32'h1);
    checkOutput("s1_addr",       bus.imem_addr, 32'h4);
    tick();
    checkOutput("s2_ifid_pc", ifIdPc, 32'h4);
    checkOutput("s2_addr",    bus.imem_addr, 32'h8);

    // Stall three cycles while pc=8 returns
    dataMode = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("hold1_req",     {31'h0, bus.imem_req}, 32'h0);
    checkOutput("hold1_ifid_pc", ifIdPc, 32'h4);
    checkOutput("hold1_valid",   {31'h0, ifIdValid}, 32'h1);
    tick();
    tick();
    checkOutput("hold3_req",     {31'h0, bus.imem_req}, 32'h0);
    checkOutput("hold3_ifid_pc", ifIdPc, 32'h4);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("unhold_ifid_pc",    ifIdPc, 32'h8);
    checkOutput("unhold_ifid_instr", ifIdInstr, 32'hA000_0008);
    checkOutput("unhold_valid",      {31'h0, ifIdValid}, 32'h1);
    checkOutput("unhold_req",        {31'h0, bus.imem_req}, 32'h1);
    checkOutput("unhold_addr",       bus.imem_addr, 32'hC);
    tick();
    checkOutput("resume_ifid_pc", ifIdPc, 32'hC);
    checkOutput("resume_addr",    bus.imem_addr, 32'h10);

    // Branch with a same-cycle response at pc=16
    applyStimulus(1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("br_valid", {31'h0, ifIdValid}, 32'h0);
    checkOutput("br_instr", ifIdInstr, 32'h0000_0013);
    checkOutput("br_addr",  bus.imem_addr, 32'h100);
    tick();
    checkOutput("br_next_pc",    ifIdPc, 32'h100);
    checkOutput("br_next_valid", {31'h0, ifIdValid}, 32'h1);
    checkOutput("br_next_addr",  bus.imem_addr, 32'h104);

    // Slow memory: jump one cycle after the pc=20 request
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h14, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    memLatency = 4'd3;
    #1;
    checkOutput("lat_addr",  bus.imem_addr, 32'h14);
    checkOutput("lat_valid", {31'h0, ifIdValid}, 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h200, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("disc_addr_hold1", bus.imem_addr, 32'h14);
    checkOutput("disc_req",        {31'h0, bus.imem_req}, 32'h1);
    tick();
    checkOutput("disc_addr_hold2", bus.imem_addr, 32'h14);
    tick();
    checkOutput("disc_new_addr", bus.imem_addr, 32'h200);
    checkOutput("disc_dropped",  {31'h0, ifIdValid}, 32'h0);

    // Newest redirect wins while discarding
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h280, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h300, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("disc2_addr_hold", bus.imem_addr, 32'h200);
    tick();
    tick();
    checkOutput("disc2_new_addr", bus.imem_addr, 32'h300);

    // Branch and jump together, misaligned branch target
    memLatency = 4'd0;
    applyStimulus(1'b1, 32'h403, 1'b1, 32'h500, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("prio_addr",  bus.imem_addr, 32'h400);
    checkOutput("prio_valid", {31'h0, ifIdValid}, 32'h0);
    tick();
    checkOutput("prio_ifid_pc", ifIdPc, 32'h400);
    checkOutput("prio_ifid_v",  {31'h0, ifIdValid}, 32'h1);

    // Redirect overrides stall
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h600, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("stjmp_addr",  bus.imem_addr, 32'h600);
    checkOutput("stjmp_valid", {31'h0, ifIdValid}, 32'h0);
    checkOutput("stjmp_instr", ifIdInstr, 32'h0000_0013);
    tick();
    checkOutput("pre_rst_ifid_pc", ifIdPc, 32'h600);

    // Reset asserted mid-HOLD with the buffer full
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("pre_rst_req", {31'h0, bus.imem_req}, 32'h0);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_req",   {31'h0, bus.imem_req}, 32'h0);
    checkOutput("mid_rst_valid", {31'h0, ifIdValid}, 32'h0);
    checkOutput("mid_rst_instr", ifIdInstr, 32'h0000_0013);
    checkOutput("mid_rst_pc",    ifIdPc, 32'h0);
    checkOutput("mid_rst_addr",  bus.imem_addr, 32'h0);
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("post_rst_addr", bus.imem_addr, 32'h0);
    checkOutput("post_rst_req",  {31'h0, bus.imem_req}, 32'h1);
    tick();
    checkOutput("post_rst_ifid_pc",    ifIdPc, 32'h0);
    checkOutput("post_rst_ifid_instr", ifIdInstr, 32'hA000_0000);
    checkOutput("post_rst_ifid_valid", {31'h0, ifIdValid}, 32'h1);

    // PC wraps modulo 2^32
    applyStimulus(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("wrap_top_addr", bus.imem_addr, 32'hFFFF_FFFC);
    tick();
    checkOutput("wrap_addr",       bus.imem_addr, 32'h0);
    checkOutput("wrap_ifid_pc",    ifIdPc, 32'hFFFF_FFFC);
    checkOutput("wrap_ifid_instr", ifIdInstr, 32'hFFFF_FFFC);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
